// File: rtl/mmu_pkg.sv
// Types and the saturating-add helper used by the MAC processing element.
package mmu_pkg;

  typedef enum logic {
    WS = 1'b0,
    OS = 1'b1
  } pe_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } pe_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_WS   = 2'd1,
    SEL_ACC  = 2'd2,
    SEL_FWD  = 2'd3
  } psum_sel_e;

  // Widths up to this value leave headroom in the 64-bit working sum.
  localparam int unsigned SAT_MAX_WIDTH = 62;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } sat_res_t;

  // Operands arrive already sign/zero-extended to 64 bits; the caller keeps
  // the low w bits of sum, so the unclamped case is an implicit modulo wrap.
  function automatic sat_res_t sat_add_fn(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w,
                                          input logic        sgn,
                                          input logic        clamp);
    logic [63:0] full;
    logic [63:0] hi;
    logic [63:0] lo;
    sat_res_t    r;
    full = a + b;
    if (sgn) begin
      hi    = (64'd1 << (w - 1)) - 64'd1;
      lo    = ~hi;
      r.ovf = ($signed(full) > $signed(hi)) || ($signed(full) < $signed(lo));
    end else begin
      hi    = (64'd1 << w) - 64'd1;
      lo    = '0;
      r.ovf = (full > hi);
    end
    r.sum = full;
    if (r.ovf && clamp) begin
      r.sum = (sgn && full[63]) ? lo : hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational add with optional clamp and overflow flag, signed or unsigned.
module sat_add
  import mmu_pkg::*;
#(
  parameter int unsigned WIDTH    = 40,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  sat_res_t    res;

  always_comb begin
    if (sgn) begin
      a_ext = 64'($signed(a));
      b_ext = 64'($signed(b));
    end else begin
      a_ext = 64'(a);
      b_ext = 64'(b);
    end
    res = sat_add_fn(a_ext, b_ext, WIDTH, sgn, SATURATE);
    sum = WIDTH'(res.sum);
    ovf = res.ovf;
  end

endmodule

// File: rtl/mac_pe_v2.sv
// Systolic MAC processing element: weight-stationary or output-stationary,
// double-buffered weights, saturating accumulate, psum forward/drain chain.
module mac_pe_v2
  import mmu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned GUARD_BITS = 8,
  parameter  int unsigned SATURATE   = 1,
  localparam int unsigned PSUM_WIDTH = 2 * DATA_WIDTH + GUARD_BITS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_in,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  mode_in,
  input  logic                  sign_in,
  input  logic                  w_wen_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic                  w_swap_in,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  psum_vld_in,
  input  logic                  acc_clr_in,
  input  logic                  drain_in,
  output logic                  en_out,
  output logic [DATA_WIDTH-1:0] pass_out,
  output logic                  w_wen_out,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  w_swap_out,
  output logic                  drain_out,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  psum_vld_out,
  output logic                  ovf_out
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0]        shadow;
  logic [DATA_WIDTH-1:0]        active;
  logic [PSUM_WIDTH-1:0]        acc;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic [PROD_WIDTH-1:0]        prod_u;
  logic [PSUM_WIDTH-1:0]        product;
  logic [PSUM_WIDTH-1:0]        acc_base;
  logic [PSUM_WIDTH-1:0]        acc_sum;
  logic [PSUM_WIDTH-1:0]        acc_next;
  logic [PSUM_WIDTH-1:0]        ws_sum;
  logic [PSUM_WIDTH-1:0]        os_sum;
  logic [PSUM_WIDTH-1:0]        psum_next;
  logic                         ws_ovf;
  logic                         os_ovf;
  logic                         ovf_next;
  logic                         vld_next;
  logic                         acc_zero;
  pe_mode_e                     mode;
  pe_state_e                    state;
  pe_state_e                    state_next;
  psum_sel_e                    sel;

  assign mode = pe_mode_e'(mode_in);

  always_comb begin
    prod_s  = PROD_WIDTH'($signed(in)) * PROD_WIDTH'($signed(active));
    prod_u  = PROD_WIDTH'(in) * PROD_WIDTH'(active);
    product = sign_in ? PSUM_WIDTH'(prod_s) : PSUM_WIDTH'(prod_u);
  end

  // Clear is applied ahead of the adder so clear+enable yields just the product.
  assign acc_base = acc_clr_in ? '0 : acc;

  sat_add #(
    .WIDTH    (PSUM_WIDTH),
    .SATURATE (SATURATE != 0)
  ) u_ws_add (
    .a   (psum_in),
    .b   (product),
    .sgn (sign_in),
    .sum (ws_sum),
    .ovf (ws_ovf)
  );

  sat_add #(
    .WIDTH    (PSUM_WIDTH),
    .SATURATE (SATURATE != 0)
  ) u_os_add (
    .a   (acc_base),
    .b   (product),
    .sgn (sign_in),
    .sum (os_sum),
    .ovf (os_ovf)
  );

  always_comb begin
    state_next = state;
    sel        = SEL_HOLD;
    vld_next   = 1'b0;
    acc_zero   = 1'b0;
    if (mode == OS) begin
      if (drain_in) begin
        state_next = DRAIN;
        sel        = SEL_ACC;
        vld_next   = 1'b1;
        acc_zero   = 1'b1;
      end else begin
        if (psum_vld_in) begin
          sel      = SEL_FWD;
          vld_next = 1'b1;
        end
        case (state)
          IDLE:    state_next = en_in ? ACCUM : IDLE;
          ACCUM:   state_next = ACCUM;
          DRAIN:   state_next = en_in ? ACCUM : IDLE;
          default: state_next = IDLE;
        endcase
      end
    end else begin
      state_next = IDLE;
      if (en_in) begin
        sel      = SEL_WS;
        vld_next = 1'b1;
      end
    end
  end

  always_comb begin
    acc_sum = en_in ? os_sum : acc_base;
    if (mode == OS) begin
      acc_next = acc_zero ? '0 : acc_sum;
      ovf_next = (acc_clr_in ? 1'b0 : ovf_out) | (en_in & os_ovf);
    end else begin
      acc_next = acc_base;
      ovf_next = (acc_clr_in ? 1'b0 : ovf_out) | (en_in & ws_ovf);
    end
    case (sel)
      SEL_WS:  psum_next = ws_sum;
      SEL_ACC: psum_next = acc_sum;
      SEL_FWD: psum_next = psum_in;
      default: psum_next = psum_out;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      shadow       <= '0;
      active       <= '0;
      acc          <= '0;
      en_out       <= 1'b0;
      pass_out     <= '0;
      w_wen_out    <= 1'b0;
      w_out        <= '0;
      w_swap_out   <= 1'b0;
      drain_out    <= 1'b0;
      psum_out     <= '0;
      psum_vld_out <= 1'b0;
      ovf_out      <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      psum_out     <= psum_next;
      psum_vld_out <= vld_next;
      ovf_out      <= ovf_next;
      en_out       <= en_in;
      w_wen_out    <= w_wen_in;
      w_swap_out   <= w_swap_in;
      drain_out    <= drain_in;
      if (en_in) begin
        pass_out <= in;
      end
      if (w_wen_in) begin
        shadow <= w_in;
        w_out  <= shadow;
      end
      if (w_swap_in) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: doc/mac_pe_v2.md
MAC_PE_V2 -- requirements
Module: mac_pe_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width.
REQ-002 SHALL have parameter GUARD_BITS, default 8, extra accumulator bits; PSUM_WIDTH = 2*DATA_WIDTH+GUARD_BITS (localparam).
REQ-003 SHALL have parameter SATURATE, default 1, 1 = clamp on overflow, 0 = wrap.
REQ-004 SHALL have ports: clk in 1 clock; rstn in 1 reset. One clock; reset asynchronous, active-low.
REQ-005 SHALL have ports: en_in in 1 operand valid; in in DATA_WIDTH activation; mode_in in 1 0=weight-stationary(WS) 1=output-stationary(OS); sign_in in 1 1=signed operands.
REQ-006 SHALL have ports: w_wen_in in 1 weight-chain shift; w_in in DATA_WIDTH weight chain data; w_swap_in in 1 shadow->active swap token.
REQ-007 SHALL have ports: psum_in in PSUM_WIDTH upstream psum; psum_vld_in in 1 upstream psum valid; acc_clr_in in 1 clear accumulator; drain_in in 1 OS drain token.
REQ-008 SHALL have outputs: en_out 1; pass_out DATA_WIDTH; w_wen_out 1; w_out DATA_WIDTH; w_swap_out 1; drain_out 1; psum_out PSUM_WIDTH; psum_vld_out 1; ovf_out 1 sticky overflow.

Function
REQ-009 SHALL register every output; en_out, w_wen_out, w_swap_out, drain_out SHALL equal the corresponding input delayed one cycle.
REQ-010 SHALL load pass_out <= in when en_in=1, else hold.
REQ-011 SHALL hold two weight registers: shadow and active; shadow <= w_in when w_wen_in=1; w_out <= shadow when w_wen_in=1, else hold (weight shift chain, one hop per cycle).
REQ-012 SHALL copy shadow to active on cycle w_swap_in=1; if w_wen_in=1 same cycle, active takes old shadow value, shadow takes w_in.
REQ-013 SHALL compute product = in * active, signed if sign_in=1 else unsigned, sign/zero-extended to PSUM_WIDTH.
REQ-014 WS mode: when en_in=1, psum_out <= sat(psum_in + product), psum_vld_out <= 1; when en_in=0, psum_vld_out <= 0, psum_out holds. Latency 1 cycle.
REQ-015 OS mode: when en_in=1, acc <= sat(acc + product); psum_in SHALL be ignored for accumulation.
REQ-016 OS mode drain: on drain_in=1, psum_out <= acc (including any same-cycle product), psum_vld_out <= 1, acc <= 0; else if psum_vld_in=1, psum_out <= psum_in, psum_vld_out <= 1 (forward); else psum_vld_out <= 0.
REQ-017 drain_in and psum_vld_in both 1 SHALL give drain priority; upstream value is dropped (controller must not schedule this).
REQ-018 acc_clr_in=1 SHALL set acc <= 0 and ovf_out <= 0; if en_in=1 same cycle, acc <= product (clear then accumulate).
REQ-019 Overflow: signed mode range [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1], unsigned [0, 2^PSUM_WIDTH-1]; on overflow ovf_out <= 1 (sticky) and result clamps to bound if SATURATE=1, else wraps modulo 2^PSUM_WIDTH.
REQ-020 mode_in change SHALL take effect next cycle; acc SHALL NOT be cleared by mode change.
REQ-021 Internal mode FSM: IDLE (no en_in), ACCUM (en_in seen, OS), DRAIN (drain_in cycle); DRAIN returns to IDLE, or to ACCUM if en_in=1; FSM drives only psum_vld_out/acc select.

Reset
REQ-022 rstn=0 SHALL asynchronously clear all outputs, shadow, active, acc, FSM (IDLE) to 0.
REQ-023 Reset mid-accumulation or mid-drain SHALL discard acc and in-flight tokens; first cycle after release behaves as from IDLE.

Structure
REQ-024 Shared package mmu_pkg SHALL hold pe_mode_e (WS, OS), pe_state_e (IDLE, ACCUM, DRAIN) and saturating-add function.
REQ-025 Sub-module sat_add (PSUM_WIDTH, signed select, SATURATE) SHALL implement add + clamp + overflow flag combinationally.

Verification
REQ-026 WS unsigned: active=3, in=5, psum_in=10, en_in=1 -> next cycle psum_out=25, psum_vld_out=1, pass_out=5.
REQ-027 Weight chain: w_wen_in=1 for 2 cycles with w_in=7 then 9 -> shadow=9, w_out=7; w_swap_in=1 -> active=9, w_swap_out=1 next cycle.
REQ-028 OS signed: acc_clr, then 4 cycles in=-2, active=3 -> acc=-24; drain_in=1 -> psum_out=-24, psum_vld_out=1, acc=0.
REQ-029 Saturation: DATA_WIDTH=8, GUARD_BITS=0, signed, acc near max, add 127*127 repeatedly -> psum clamps 32767, ovf_out=1 until acc_clr_in.
REQ-030 Forward: OS, psum_vld_in=1, psum_in=0x1234, drain_in=0 -> psum_out=0x1234; drain and psum_vld_in same cycle -> own acc output.
REQ-031 Reset: assert rstn=0 mid-ACCUM with acc=50 -> all outputs 0 immediately; after release, drain yields 0.
